// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the multiply/divide unit.
// Operation codes are also used by the decoder and the stall unit.
package mul_div_unit_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } md_state_e;

    function automatic logic is_long_op(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_md_calc.sv
// Combinational arithmetic core for mult/multu/div/divu.
// Produces {hi,lo} and flags a zero divisor on divide ops.
module md_calc
    import mul_div_unit_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_result,
    output logic        o_div_by_zero
);

    logic signed [63:0] w_a_sx;
    logic signed [63:0] w_b_sx;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;

    logic        w_sgn;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_dvs_safe;
    logic [31:0] w_quo_mag;
    logic [31:0] w_rem_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_a_sx   = {{32{i_a[31]}}, i_a};
    assign w_b_sx   = {{32{i_b[31]}}, i_b};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly.
    assign w_sgn   = (i_op == MD_DIV);
    assign w_a_neg = w_sgn & i_a[31];
    assign w_b_neg = w_sgn & i_b[31];
    assign w_dvd   = w_a_neg ? (~i_a + 32'd1) : i_a;
    assign w_dvs   = w_b_neg ? (~i_b + 32'd1) : i_b;

    assign w_dvs_safe = (i_b == 32'd0) ? 32'd1 : w_dvs;
    assign w_quo_mag  = w_dvd / w_dvs_safe;
    assign w_rem_mag  = w_dvd % w_dvs_safe;

    assign w_quo = (w_a_neg ^ w_b_neg) ? (~w_quo_mag + 32'd1) : w_quo_mag;
    assign w_rem = w_a_neg ? (~w_rem_mag + 32'd1) : w_rem_mag;

    assign o_div_by_zero = is_div_op(i_op) && (i_b == 32'd0);

    always_comb begin
        o_result = '0;
        case (i_op)
            MD_MULT:         o_result = w_prod_s;
            MD_MULTU:        o_result = w_prod_u;
            MD_DIV, MD_DIVU: o_result = {w_rem, w_quo};
            default:         o_result = '0;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Result is computed at issue and committed when the busy window ends.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDop,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic        read_hi,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam int CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    md_state_e r_state;
    md_state_e w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_lat;
    logic [63:0]      r_res;
    logic             r_div0;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic [63:0] w_calc;
    logic        w_div0;
    logic        w_issue;
    logic        w_done;
    logic        w_mthi;
    logic        w_mtlo;

    md_calc u_calc (
        .i_op          (MDop),
        .i_a           (operand1),
        .i_b           (operand2),
        .o_result      (w_calc),
        .o_div_by_zero (w_div0)
    );

    assign w_lat = is_div_op(MDop) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (is_long_op(MDop)) begin
                        w_issue     = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                    w_mthi = (MDop == MD_MTHI);
                    w_mtlo = (MDop == MD_MTLO);
                end
            end
            ST_RUN: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_res  <= '0;
            r_div0 <= 1'b0;
        end else if (w_issue) begin
            r_cnt  <= w_lat;
            r_res  <= w_calc;
            r_div0 <= w_div0;
        end else if (r_state == ST_RUN && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // A zero divisor still burns the full window but leaves HI/LO alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            if (!r_div0) begin
                r_hi <= r_res[63:32];
                r_lo <= r_res[31:0];
            end
        end else begin
            if (w_mthi) r_hi <= operand1;
            if (w_mtlo) r_lo <= operand1;
        end
    end

    assign busy  = (r_state == ST_RUN);
    assign HI    = r_hi;
    assign LO    = r_lo;
    assign MDOut = read_hi ? r_hi : r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: driver queues expected results,
// monitor checks HI/LO and busy length when busy falls.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  MDop = MD_NONE;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic        read_hi = 1'b0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mul_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .MDop     (MDop),
        .operand1 (operand1),
        .operand2 (operand2),
        .read_hi  (read_hi),
        .busy     (busy),
        .HI       (HI),
        .LO       (LO),
        .MDOut    (MDOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        MDop = op;
        operand1 = a;
        operand2 = b;
        @(negedge clk);
        start = 1'b0;
        MDop = MD_NONE;
    endtask

    task automatic push(input string nm, input logic [31:0] hi,
                        input logic [31:0] lo, input int cyc);
        exp_t e;
        e.name = nm;
        e.hi = hi;
        e.lo = lo;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic run_op(input string nm, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo,
                          input int cyc);
        bit ok;
        push(nm, hi, lo, cyc);
        issue(op, a, b);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (!busy) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL %s timeout: busy still %b after 40 cycles", nm, busy);
        end
    endtask

    task automatic move(input string nm, input logic [3:0] op,
                        input logic [31:0] v);
        issue(op, v, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        if (op == MD_MTHI) begin
            chk({nm, "_hi"}, HI, v);
            m_hi = v;
        end else begin
            chk({nm, "_lo"}, LO, v);
            m_lo = v;
        end
    endtask

    // Monitor: HI/LO must hold during busy; completion pops the scoreboard.
    initial begin
        bit prev = 1'b0;
        int run = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
                run = 0;
            end else begin
                if (busy === 1'b1) begin
                    run++;
                    chk("hold_hi", HI, m_hi);
                    chk("hold_lo", LO, m_lo);
                end else if (prev) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_done: got completion expected none");
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_hi"}, HI, e.hi);
                        chk({e.name, "_lo"}, LO, e.lo);
                        chk({e.name, "_cycles"}, 32'(run), 32'(e.cyc));
                        m_hi = e.hi;
                        m_lo = e.lo;
                    end
                    run = 0;
                end
                prev = (busy === 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12 reset = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;

        move("mthi", MD_MTHI, 32'h12345678);
        move("mtlo", MD_MTLO, 32'h9ABCDEF0);
        chk("mtlo_hi_kept", HI, 32'h12345678);
        read_hi = 1'b1;
        #1 chk("mdout_hi", MDOut, 32'h12345678);
        read_hi = 1'b0;
        #1 chk("mdout_lo", MDOut, 32'h9ABCDEF0);

        run_op("mult", MD_MULT, 32'hFFFFFFFE, 32'd3,
               32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        run_op("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3,
               32'h00000002, 32'hFFFFFFFA, 5);
        run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        run_op("divu", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF,
               32'd0, 32'h80000000, 10);
        run_op("div_negdvs", MD_DIV, 32'd7, 32'hFFFFFFFE,
               32'd1, 32'hFFFFFFFD, 10);

        move("pre_hi", MD_MTHI, 32'hAAAA0000);
        move("pre_lo", MD_MTLO, 32'h0000BBBB);
        run_op("divu_zero", MD_DIVU, 32'd5, 32'd0,
               32'hAAAA0000, 32'h0000BBBB, 10);

        push("busy_ign", 32'd0, 32'd12, 5);
        issue(MD_MULT, 32'd3, 32'd4);
        start = 1'b1;
        MDop = MD_DIV;
        operand1 = 32'd100;
        operand2 = 32'd7;
        @(negedge clk);
        MDop = MD_MTLO;
        operand1 = 32'h0000DEAD;
        @(negedge clk);
        start = 1'b0;
        MDop = MD_NONE;
        repeat (5) @(negedge clk);
        chk("busy_ign_idle", {31'd0, busy}, 32'd0);
        chk("busy_ign_lo", LO, 32'd12);

        push("div_rst", 32'd2, 32'd14, 10);
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_hi", HI, 32'd0);
        chk("mid_rst_lo", LO, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("no_late_busy", {31'd0, busy}, 32'd0);
        chk("no_late_lo", LO, 32'd0);
        chk("no_late_hi", HI, 32'd0);

        run_op("mult_after_rst", MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 5);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit for the pipelined MIPS core. It executes the mult, multu, div and divu operations, which the ALU does not handle, and owns the HI/LO architectural registers.
- The E stage issues operations through a start/busy handshake. The stall unit uses `busy | start` to hold any later mult/div/mfhi/mflo/mthi/mtlo in D.
- A read port serves mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, number of cycles busy stays high for mult/multu.
- DIV_CYCLES, 10, number of cycles busy stays high for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue strobe. It is sampled only when MDop is valid and busy is 0.
- MDop  input  4  operation code. 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
- operand1  input  32  rs value: multiplicand, dividend, or the mthi/mtlo data.
- operand2  input  32  rt value: multiplier or divisor.
- read_hi  input  1  1 selects HI on MDOut, 0 selects LO.
- busy  output  1  operation in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- MDOut  output  32  combinational value of HI or LO, chosen by read_hi.

Behaviour:
- States: IDLE and RUN. A down-counter `cnt` runs in RUN.
- Reset (async, any time, including mid-operation):
  - Go to IDLE.
  - busy=0, HI=0, LO=0, cnt=0.
  - The pending result is discarded.
- IDLE, start=1, MDop in {1..4}, at edge T:
  - Compute the 64-bit result from operand1/operand2 as captured at T. Store it in internal registers res_hi/res_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES. Enter RUN. busy=1 from T+1.
- RUN: cnt decrements each edge. On the edge where cnt reaches 0:
  - HI<=res_hi and LO<=res_lo.
  - busy<=0 and the state returns to IDLE.
  - So busy is high for exactly N cycles, and HI/LO change on the same edge busy falls.
- HI/LO keep their old values during RUN. MDOut reflects those old values.
- MTHI/MTLO with start=1 in IDLE: HI (or LO) <= operand1 on that edge. busy stays 0 (single cycle).
- start while busy=1: ignored entirely. The operation in flight is unaffected. The stall unit prevents this, but the block must be robust to it.
- start with MDop=0 or MDop>6: no effect.
- Arithmetic rules:
  - MULT: signed 32x32 multiply to a 64-bit result. HI=[63:32], LO=[31:0].
  - MULTU: unsigned 32x32 multiply, same HI/LO split.
  - DIV: signed. LO = quotient truncated toward zero. HI = remainder, which takes the sign of the dividend.
  - DIVU: unsigned. LO = quotient, HI = remainder.
- Divisor 0 (div/divu): the full busy period still runs, and HI/LO are left unchanged at completion.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Back-to-back operations: start is accepted the cycle after busy falls, not on the falling edge itself.

Decomposition:
- Shared header/package holds:
  - the MDop encodings as named constants (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - the default latency constants.
  - The decoder and stall unit use the same constants.
- One sub-module, md_calc: purely combinational. It takes MDop, operand1 and operand2 and produces the 64-bit {hi,lo} result plus a div_by_zero flag.
- The FSM, counter and HI/LO registers stay in mul_div_unit.

Test Plan:
- Reset then idle: assert reset mid-cycle, asynchronously -> busy=0, HI=LO=0 immediately. Then MTHI 0x12345678 and MTLO 0x9ABCDEF0 -> HI=0x12345678, LO=0x9ABCDEF0 one edge later, busy never rises.
- MULT 0xFFFFFFFE (-2) x 0x00000003 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. With the same operands, MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: preload HI=0xAAAA0000, LO=0x0000BBBB, then DIVU 5/0 -> busy for 10 cycles; HI/LO unchanged afterwards.
- Start while busy: issue MULT 3x4, then at cycle 2 of busy issue DIV 100/7 and MTLO 0xDEAD -> both ignored; after 5 cycles HI=0, LO=12, busy=0.
- Reset mid-operation: issue DIV 100/7 and assert reset at busy cycle 4 -> busy=0 and HI=LO=0 immediately, and no late write occurs. A fresh MULT 6x7 after reset -> LO=42 after 5 cycles.
